dmem_arbiter: RTL

Shares the single-port data memory between two requesters: the CPU MEM stage (port C) and a debug/DMA loader (port D).
- Grants at most one access per cycle.
- Routes read data back to the owner one cycle later.
- Stalls the CPU pipeline when the CPU loses arbitration.
- Sits between the EX/MEM pipeline register outputs and the data_memory instance.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_rd_return.sv | 46 ++++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, owner tags, starvation default.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_CPU_PRI = 1'b0,
    ARB_DMA_PRI = 1'b1
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_CNT_W   = 4;
  localparam int unsigned STAT_W         = 16;

endpackage

// File: rtl/dmem_arbiter_rd_return.sv
// Read-return path: remembers who owns the read in flight and delivers the
// memory data to that port one cycle after the grant.
module arb_rd_return
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic              rd_fire,
  input  logic              rd_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid
);

  logic              pend_q;
  logic              owner_q;
  logic [DATA_W-1:0] cpu_hold_q;
  logic [DATA_W-1:0] dma_hold_q;

  // Pending flag and owner tag registered on a granted read; holds capture the returned word.
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      pend_q     <= 1'b0;
      owner_q    <= OWN_CPU;
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      pend_q <= rd_fire;
      if (rd_fire) owner_q <= rd_owner;
      if (cpu_rvalid) cpu_hold_q <= mem_rdata;
      if (dma_rvalid) dma_hold_q <= mem_rdata;
    end
  end

  // Memory data arrives the cycle after the grant, so it is forwarded straight through
  // while rvalid is high and the hold register keeps it afterwards; reset drops the return.
  assign cpu_rvalid = ~pc_reset & pend_q & (owner_q == OWN_CPU);
  assign dma_rvalid = ~pc_reset & pend_q & (owner_q == OWN_DMA);
  assign cpu_rdata  = pc_reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_hold_q);
  assign dma_rdata  = pc_reset ? '0 : (dma_rvalid ? mem_rdata : dma_hold_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the DMA loader.
// Optional build macro DMEM_ARB_STATS_EN adds saturating stall/wait counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_cpu_stall,
  output logic [STAT_W-1:0] stat_dma_wait,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LAST = STARVE_CNT_W'(STARVE_MAX - 1);

  arb_state_e              state;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    cpu_grant;
  logic                    dma_grant;
  logic                    dma_denied;

  // Grant decision: a lone requester wins, a conflict goes to the priority holder.
  always_comb begin
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (!pc_reset) begin
      dma_grant = dma_req & (~cpu_req | (state == ARB_DMA_PRI));
      cpu_grant = cpu_req & ~dma_grant;
    end
  end

  assign dma_denied = dma_req & ~dma_grant;
  assign cpu_stall  = ~pc_reset & cpu_req & ~cpu_grant;
  assign dma_gnt    = dma_grant;
  assign mem_addr   = dma_grant ? dma_addr  : cpu_addr;
  assign mem_wdata  = dma_grant ? dma_wdata : cpu_wdata;
  assign mem_read   = (cpu_grant & ~cpu_we) | (dma_grant & ~dma_we);
  assign mem_write  = (cpu_grant &  cpu_we) | (dma_grant &  dma_we);

  // Priority FSM and DMA starvation counter.
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state      <= ARB_CPU_PRI;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= dma_denied ? starve_cnt + STARVE_CNT_W'(1) : '0;
      case (state)
        ARB_CPU_PRI: if (dma_denied && (starve_cnt == STARVE_LAST)) state <= ARB_DMA_PRI;
        ARB_DMA_PRI: if (dma_grant || !dma_req) state <= ARB_CPU_PRI;
      endcase
    end
  end

  arb_rd_return #(.DATA_W(DATA_W)) u_rd_return (
    .clk        (clk),
    .pc_reset   (pc_reset),
    .rd_fire    (mem_read),
    .rd_owner   (dma_grant ? OWN_DMA : OWN_CPU),
    .mem_rdata  (mem_rdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid)
  );

`ifdef DMEM_ARB_STATS_EN
  // Saturating counts of CPU stall cycles and DMA wait cycles.
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      stat_cpu_stall <= '0;
      stat_dma_wait  <= '0;
    end else begin
      if (cpu_stall  && (stat_cpu_stall != '1)) stat_cpu_stall <= stat_cpu_stall + STAT_W'(1);
      if (dma_denied && (stat_dma_wait  != '1)) stat_dma_wait  <= stat_dma_wait  + STAT_W'(1);
    end
  end
`endif

endmodule
